led_state_sequencer: RTL



---
 rtl/led_state_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/led_state_sequencer.sv
// -----------------------------------------------------------------------------
// led_state_sequencer
//
// Holds a registered one-hot LED state vector. The current state index is
// either loaded directly from a binary selector or advanced automatically
// after a programmable dwell time. Sits between mode/control logic and the
// LED output drivers.
//
// Optional build macro: BOUNCE_MODE_EN
//   undefined : auto stepping counts up and wraps NUM_STATES-1 -> 0
//   defined   : auto stepping ping-pongs 0..N-1..0, with a direction register
//
// Ports:
//   clk        in   1           system clock, rising edge
//   rst        in   1           synchronous reset, active-high
//   sel        in   SEL_W       binary state index for direct load
//   load       in   1           one-cycle strobe: load state from sel
//   auto_en    in   1           level: enable automatic stepping
//   dwell      in   DWELL_W     cycles-per-state minus one while stepping
//   state      out  NUM_STATES  registered one-hot state vector
//   state_idx  out  SEL_W       registered binary index of current state
//   wrap       out  1           one-cycle pulse on wrap / turnaround
// -----------------------------------------------------------------------------
module led_state_sequencer #(
  parameter int NUM_STATES = 6,
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  load,
  input  logic                  auto_en,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [NUM_STATES-1:0] state,
  output logic [SEL_W-1:0]      state_idx,
  output logic                  wrap
);

  // One extra bit so NUM_STATES == 2**SEL_W still fits for the range check.
  localparam logic [SEL_W:0]   NUM_EXT  = (SEL_W+1)'(NUM_STATES);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_STATES-1);
  localparam logic [SEL_W-1:0] ZERO_IDX = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] ONE_IDX  = SEL_W'(1);
  localparam logic [DWELL_W-1:0] ZERO_CNT = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] ONE_CNT  = DWELL_W'(1);

  // One-hot decode of a binary index.
  function automatic logic [NUM_STATES-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_STATES-1:0] v;
    v = {NUM_STATES{1'b0}};
    for (int i = 0; i < NUM_STATES; i++) begin
      v[i] = (idx == SEL_W'(i));
    end
    return v;
  endfunction

  logic [SEL_W-1:0]      idx_q,   idx_d;
  logic [NUM_STATES-1:0] state_q, state_d;
  logic [DWELL_W-1:0]    cnt_q,   cnt_d;
  logic                  wrap_q,  wrap_d;
  logic                  step_s;

`ifdef BOUNCE_MODE_EN
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  logic dir_q, dir_d;
`endif

  // Dwell counter and step-due decision; load has priority over stepping.
  always_comb begin
    cnt_d  = cnt_q;
    step_s = 1'b0;
    if (load) begin
      cnt_d = ZERO_CNT;
    end else if (auto_en) begin
      // >= so that lowering dwell mid-count steps at once instead of overrunning.
      if (cnt_q >= dwell) begin
        cnt_d  = ZERO_CNT;
        step_s = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE_CNT;
      end
    end else begin
      cnt_d = ZERO_CNT;
    end
  end

`ifdef BOUNCE_MODE_EN
  // Next index / wrap / direction in ping-pong mode.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    dir_d  = dir_q;
    if (load) begin
      if ({1'b0, sel} < NUM_EXT) begin
        idx_d = sel;
      end else begin
        idx_d = ZERO_IDX;
      end
    end else if (step_s) begin
      if (dir_q == DIR_UP) begin
        // A load may have parked us on the top state while heading up.
        if (idx_q >= LAST_IDX) begin
          idx_d = idx_q - ONE_IDX;
          dir_d = DIR_DOWN;
        end else begin
          idx_d = idx_q + ONE_IDX;
        end
      end else begin
        if (idx_q == ZERO_IDX) begin
          idx_d = ONE_IDX;
          dir_d = DIR_UP;
        end else begin
          idx_d = idx_q - ONE_IDX;
        end
      end
      // Reaching either end is a turnaround: flip and pulse wrap.
      if (idx_d == LAST_IDX) begin
        dir_d  = DIR_DOWN;
        wrap_d = 1'b1;
      end else if (idx_d == ZERO_IDX) begin
        dir_d  = DIR_UP;
        wrap_d = 1'b1;
      end else begin
        wrap_d = 1'b0;
      end
    end else begin
      idx_d = idx_q;
    end
    state_d = onehot(idx_d);
  end
`else
  // Next index / wrap in circular mode.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (load) begin
      if ({1'b0, sel} < NUM_EXT) begin
        idx_d = sel;
      end else begin
        idx_d = ZERO_IDX;
      end
    end else if (step_s) begin
      if (idx_q == LAST_IDX) begin
        idx_d  = ZERO_IDX;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + ONE_IDX;
      end
    end else begin
      idx_d = idx_q;
    end
    state_d = onehot(idx_d);
  end
`endif

  // State registers; one-hot vector is registered alongside the index.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= ZERO_IDX;
      state_q <= onehot(ZERO_IDX);
      cnt_q   <= ZERO_CNT;
      wrap_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef BOUNCE_MODE_EN
  // Direction register for ping-pong stepping; load leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= DIR_UP;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  assign state     = state_q;
  assign state_idx = idx_q;
  assign wrap      = wrap_q;

endmodule
